// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32I instruction fields into 32-bit words and emits
// each word with its instruction-memory byte address. Illegal bundles are
// consumed without emitting anything and are counted in err/err_count.
// The encoder stops accepting input after MAX_WORDS legal words.
module instr_encoder #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_kind,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              done,
    output logic              err,
    output logic [7:0]        err_count
);

    localparam int unsigned CNT_W = $clog2(MAX_WORDS + 1);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        K_LOAD   = 4'd0,
        K_STORE  = 4'd1,
        K_RTYPE  = 4'd2,
        K_BRANCH = 4'd3,
        K_ITYPE  = 4'd4,
        K_JAL    = 4'd5,
        K_JALR   = 4'd6,
        K_LUI    = 4'd7,
        K_AUIPC  = 4'd8
    } kind_t;

    typedef enum logic {
        S_RUN,
        S_FULL
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr_cnt;
    logic [CNT_W-1:0]  word_cnt;
    logic [31:0]       enc_word;
    logic              enc_legal;
    logic              accept;
    logic              accept_legal;
    logic              accept_illegal;

    // Immediate range checks: the sign bits above each format's field must agree.
    logic imm_is_ok;
    logic imm_b_ok;
    logic imm_j_ok;
    logic imm_u_ok;

    assign imm_is_ok = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign imm_b_ok  = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];
    assign imm_j_ok  = ((&in_imm[31:20]) | ~(|in_imm[31:20])) & ~in_imm[0];
    assign imm_u_ok  = ~(|in_imm[11:0]);

    // Input is taken only in RUN and only when the output slot is free or draining.
    assign in_ready       = (state == S_RUN) && (!out_valid || out_ready);
    assign accept         = in_valid && in_ready;
    assign accept_legal   = accept && enc_legal;
    assign accept_illegal = accept && !enc_legal;
    assign done           = (state == S_FULL);

    // Combinational field packing and legality per instruction kind.
    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b0;
        case (in_kind)
            K_LOAD: begin
                enc_legal = imm_is_ok;
                enc_word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
            end
            K_ITYPE: begin
                enc_legal = imm_is_ok;
                enc_word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_ITYPE};
            end
            K_JALR: begin
                enc_legal = imm_is_ok;
                enc_word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_JALR};
            end
            K_STORE: begin
                enc_legal = imm_is_ok;
                enc_word  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
            end
            K_RTYPE: begin
                enc_legal = 1'b1;
                enc_word  = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, OP_RTYPE};
            end
            K_BRANCH: begin
                enc_legal = imm_b_ok;
                enc_word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                             in_imm[4:1], in_imm[11], OP_BRANCH};
            end
            K_JAL: begin
                enc_legal = imm_j_ok;
                enc_word  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
            end
            K_LUI: begin
                enc_legal = imm_u_ok;
                enc_word  = {in_imm[31:12], in_rd, OP_LUI};
            end
            K_AUIPC: begin
                enc_legal = imm_u_ok;
                enc_word  = {in_imm[31:12], in_rd, OP_AUIPC};
            end
            default: begin
                enc_word  = '0;
                enc_legal = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Move to FULL on the legal accept that completes the program.
    always_comb begin
        state_next = state;
        case (state)
            S_RUN: begin
                if (accept_legal && (word_cnt == CNT_W'(MAX_WORDS - 1))) begin
                    state_next = S_FULL;
                end
            end
            S_FULL:  state_next = S_FULL;
            default: state_next = S_RUN;
        endcase
    end

    // Address and word counters advance only on legal accepts.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_cnt <= BASE_ADDR;
            word_cnt <= '0;
        end else if (accept_legal) begin
            addr_cnt <= addr_cnt + ADDR_W'(4);
            word_cnt <= word_cnt + CNT_W'(1);
        end
    end

    // Output register: a legal accept reloads it even while draining, so no bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_addr  <= BASE_ADDR;
        end else if (accept_legal) begin
            out_valid <= 1'b1;
            out_instr <= enc_word;
            out_addr  <= addr_cnt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky error flag and saturating count of rejected bundles.
    always_ff @(posedge clk) begin
        if (reset) begin
            err       <= 1'b0;
            err_count <= '0;
        end else if (accept_illegal) begin
            err <= 1'b1;
            if (err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential RISC-V RV32I instruction encoder, the inverse of the core's main decoder. It accepts instruction fields (kind, registers, funct3/funct7, 32-bit immediate) over a valid/ready handshake, range-checks the immediate for the kind's format, and packs a 32-bit instruction word. Each word is emitted with its instruction-memory byte address over a second valid/ready handshake. It sits between the test/boot program generator and the instruction-memory write port, and stops after a fixed program length.

## Interface
- `ADDR_W`, 32: width of the emitted byte address.
- `BASE_ADDR`, 0: address of the first emitted word; must be 4-byte aligned.
- `MAX_WORDS`, 256: program length in words; must be ≥1.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `in_valid` input 1: field bundle valid.
- `in_ready` output 1: bundle accepted when `in_valid && in_ready`.
- `in_kind` input 4: 0 LOAD, 1 STORE, 2 RTYPE, 3 BRANCH, 4 ITYPE, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC; 9–15 illegal.
- `in_rd`, `in_rs1`, `in_rs2` input 5 each: register indices.
- `in_funct3` input 3, `in_funct7` input 7: function fields.
- `in_imm` input 32: byte-offset/value immediate, sign-extended.
- `out_valid` output 1: word/address valid.
- `out_ready` input 1: memory accepts when `out_valid && out_ready`.
- `out_instr` output 32: encoded word.
- `out_addr` output ADDR_W: byte address of `out_instr`.
- `done` output 1: `MAX_WORDS` words accepted at the input.
- `err` output 1: sticky; set by any rejected bundle.
- `err_count` output 8: count of rejected bundles, saturating at 255.

## Operation
- Opcodes: LOAD 0000011, STORE 0100011, RTYPE 0110011, BRANCH 1100011, ITYPE 0010011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
- Encoding formats:
  - I (LOAD, ITYPE, JALR): {imm[11:0], rs1, f3, rd, op}.
  - S: {imm[11:5], rs2, rs1, f3, imm[4:0], op}.
  - R: {f7, rs2, rs1, f3, rd, op}.
  - B: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
  - U (LUI, AUIPC): {imm[31:12], rd, op}.
- Legality checks:
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
  - U: imm[11:0]=0.
  - R: always legal.
  - Kind 9–15: illegal.
- Illegal bundle handling: consumed normally (handshake completes), no word emitted, no address or word-count advance; sets `err` and increments `err_count`.
- State machine:
  - RUN: `in_ready = !done_cnt && (!out_valid || out_ready)`.
  - FULL: entered when the accepted-legal count reaches `MAX_WORDS`; `done=1`, `in_ready=0`. The output register still drains. Exit only by `reset`.
- Address counter: starts at `BASE_ADDR`, +4 per legal accept, modulo 2^ADDR_W (wrap permitted, no flag).
- Output register: loaded on a legal accept. `out_valid` clears on an output handshake with no simultaneous legal accept. Simultaneous drain and accept in the same cycle replaces the contents with no bubble.
- While `out_valid && !out_ready`: `out_instr`/`out_addr` hold stable and `in_ready=0`.

## Timing
- Latency: legal accept at edge N gives `out_valid=1` with the word in cycle N+1 (registered output, combinational encode before the register).
- Throughput: 1 word/cycle with `out_ready` held high.
- `in_ready` depends combinationally on `out_ready` (pass-through stall).
- Reset values: `out_valid=0`, `out_instr=0`, `out_addr=BASE_ADDR`, `done=0`, `err=0`, `err_count=0`, address counter `BASE_ADDR`, word count 0, state RUN.
- Reset mid-transfer discards the held word; `in_ready=1` in the first cycle after reset.
- `done` rises the cycle after the `MAX_WORDS`-th legal accept.
- Illegal bundle: `err` and `err_count` update one cycle after the accept.

## Test plan
- ITYPE rd=1, rs1=0, f3=0, imm=5 → `out_instr=0x00500093`, `out_addr=BASE_ADDR`, one cycle after accept.
- Back-to-back stream with `out_ready=1`:
  - LOAD rd=2, rs1=1, f3=2, imm=8 → 0x0080A103.
  - STORE rs2=2, rs1=1, f3=2, imm=12 → 0x0020A623.
  - BRANCH rs1=1, rs2=2, f3=0, imm=-4 → 0xFE208EE3.
  - JAL rd=1, imm=8 → 0x008000EF.
  - LUI rd=5, imm=0x12345000 → 0x123452B7.
  - Required: addresses +4 apart, no bubbles.
- Illegal bundles (kind 9; ITYPE imm=2048; BRANCH imm=3) → accepted, nothing emitted, `err=1`, `err_count=3`, next legal word at the next unused address.
- Hold `out_ready=0` for 5 cycles with a word pending → word/address stable, `in_ready=0`; release → drain plus new accept in the same cycle.
- `MAX_WORDS=4`, `BASE_ADDR=0xFFFFFFF8` → addresses F8, FC, 00, 04; `done=1` after the 4th; `in_ready` stays 0.
- Assert `reset` while `out_valid=1` → next cycle `out_valid=0`, `out_addr=BASE_ADDR`, `err=0`, `done=0`.
